// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_if
//  Description : Instruction-memory and issue handshake bundle of fetch_unit.
//  Revision    : 1.0  initial release
// ============================================================================
interface fetch_if;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [3:0]  op;
    logic [11:0] operand;
    logic        issue_valid;
    logic        issue_ready;
    logic        jump;
    logic        branch;
    logic        acc_zero;

    modport master (
        output imem_req, imem_addr, op, operand, issue_valid,
        input  imem_ack, imem_rdata, issue_ready, jump, branch, acc_zero
    );

    modport slave (
        input  imem_req, imem_addr, op, operand, issue_valid,
        output imem_ack, imem_rdata, issue_ready, jump, branch, acc_zero
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch/issue sequencer with PC update on issue.
//                Define FETCH_UNIT_PREFETCH_EN for a one-entry prefetch buffer.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input  wire         clk,
    input  wire         rst,
    input  wire         run,
    fetch_if.master     bus,
    output logic [11:0] pc
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
`ifdef FETCH_UNIT_PREFETCH_EN
    localparam logic [1:0] S_DROP  = 2'd3;
`endif

    logic [1:0]  r_state, w_state_nxt;
    logic [11:0] r_pc, w_pc_nxt;
    logic [15:0] r_ir, w_ir_nxt;
    logic        w_req;
    logic [11:0] w_addr;
    logic        w_valid;
    logic        w_hs;
    logic        w_taken;
    logic [11:0] w_pc_inc;
`ifdef FETCH_UNIT_PREFETCH_EN
    logic [15:0] r_buf, w_buf_nxt;
    logic        r_buf_valid, w_buf_valid_nxt;
    logic [11:0] r_drop_addr, w_drop_addr_nxt;
`endif

    assign w_pc_inc = r_pc + 12'd1;
    assign w_hs     = (r_state == S_ISSUE) && bus.issue_ready;
    assign w_taken  = bus.jump || (bus.branch && bus.acc_zero);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_req       = 1'b0;
        w_addr      = r_pc;
        w_valid     = 1'b0;
`ifdef FETCH_UNIT_PREFETCH_EN
        w_buf_nxt       = r_buf;
        w_buf_valid_nxt = r_buf_valid;
        w_drop_addr_nxt = r_drop_addr;
`endif
        case (r_state)
            S_IDLE: begin
                if (run) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                w_req = 1'b1;
                if (bus.imem_ack) begin
                    w_ir_nxt    = bus.imem_rdata;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_valid = 1'b1;
`ifdef FETCH_UNIT_PREFETCH_EN
                w_req  = !r_buf_valid;
                w_addr = w_pc_inc;
                if (w_hs) begin
                    w_pc_nxt        = w_taken ? r_ir[11:0] : w_pc_inc;
                    w_buf_valid_nxt = 1'b0;
                    // An unacked prefetch cannot be withdrawn; drain it before leaving.
                    if (w_req && !bus.imem_ack && (w_taken || !run)) begin
                        w_drop_addr_nxt = w_pc_inc;
                        w_state_nxt     = S_DROP;
                    end else if (!run) begin
                        w_state_nxt = S_IDLE;
                    end else if (w_taken) begin
                        w_state_nxt = S_FETCH;
                    end else if (r_buf_valid) begin
                        w_ir_nxt = r_buf;
                    end else if (bus.imem_ack) begin
                        w_ir_nxt = bus.imem_rdata;
                    end else begin
                        // New pc equals the prefetch address, so FETCH continues the same request.
                        w_state_nxt = S_FETCH;
                    end
                end else if (w_req && bus.imem_ack) begin
                    w_buf_nxt       = bus.imem_rdata;
                    w_buf_valid_nxt = 1'b1;
                end
`else
                if (w_hs) begin
                    w_pc_nxt    = w_taken ? r_ir[11:0] : w_pc_inc;
                    w_state_nxt = run ? S_FETCH : S_IDLE;
                end
`endif
            end
`ifdef FETCH_UNIT_PREFETCH_EN
            S_DROP: begin
                w_req  = 1'b1;
                w_addr = r_drop_addr;
                if (bus.imem_ack) w_state_nxt = run ? S_FETCH : S_IDLE;
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_ir    <= 16'h0000;
`ifdef FETCH_UNIT_PREFETCH_EN
            r_buf       <= 16'h0000;
            r_buf_valid <= 1'b0;
            r_drop_addr <= 12'h000;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
`ifdef FETCH_UNIT_PREFETCH_EN
            r_buf       <= w_buf_nxt;
            r_buf_valid <= w_buf_valid_nxt;
            r_drop_addr <= w_drop_addr_nxt;
`endif
        end
    end

    assign bus.imem_req    = w_req;
    assign bus.imem_addr   = w_addr;
    assign bus.issue_valid = w_valid;
    assign bus.op          = w_valid ? r_ir[15:12] : 4'h0;
    assign bus.operand     = w_valid ? r_ir[11:0] : 12'h000;
    assign pc              = r_pc;

endmodule
`default_nettype wire
